// File: rtl/uart_recv.sv
`default_nettype none
// ============================================================================
// uart_recv : asynchronous serial receiver, 5-8 data bits, 1-2 stop bits
// Revision  : 1.0
// ============================================================================
module uart_recv #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RX_serial,
   input  logic [25:0] clk_freq,
   input  logic [19:0] uart_baud,
   input  logic [3:0]  data_bits_rx,
   input  logic [1:0]  stop_bits_rx,
   output logic        RX_DV,
   output logic [7:0]  RX_BYTE,
   output logic        RX_Active,
   output logic        RX_Frame_Err
);

   localparam int C_SYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START_BIT = 3'd1,
      DATA_BITS = 3'd2,
      STOP_BITS = 3'd3,
      CLEAN_UP  = 3'd4
   } state_t;

   state_t            state_q;
   logic [C_SYNC-1:0] sync_q;
   logic [13:0]       cnt_q;
   logic [13:0]       cpb_q;
   logic [2:0]        bit_idx_q;
   logic [2:0]        last_idx_q;
   logic              stop_idx_q;
   logic              two_stop_q;
   logic [7:0]        shift_q;
   logic              err_q;

   logic              w_rx_s;
   logic [13:0]       w_cpb;
   logic [13:0]       w_cpb_m1;
   logic [13:0]       w_half_m1;
   logic [2:0]        w_last_idx;
   logic              w_two_stop;
   logic [7:0]        w_mask;

   assign w_rx_s     = sync_q[C_SYNC-1];
   assign w_cpb      = 14'(clk_freq / {6'd0, uart_baud});
   assign w_cpb_m1   = cpb_q - 14'd1;
   assign w_half_m1  = (cpb_q >> 1) - 14'd1;
   // Out-of-range widths fall back to 8 bits (last index 7); 8 wraps to 7 too.
   assign w_last_idx = (data_bits_rx >= 4'd5 && data_bits_rx <= 4'd8)
                       ? (data_bits_rx[2:0] - 3'd1) : 3'd7;
   assign w_two_stop = (stop_bits_rx == 2'd2);
   assign w_mask     = 8'hFF >> (3'd7 - last_idx_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[C_SYNC-2:0], RX_serial};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         cpb_q        <= '0;
         bit_idx_q    <= '0;
         last_idx_q   <= 3'd7;
         stop_idx_q   <= 1'b0;
         two_stop_q   <= 1'b0;
         shift_q      <= '0;
         err_q        <= 1'b0;
         RX_DV        <= 1'b0;
         RX_BYTE      <= 8'h00;
         RX_Active    <= 1'b0;
         RX_Frame_Err <= 1'b0;
      end else begin
         RX_DV        <= 1'b0;
         RX_Frame_Err <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!w_rx_s) begin
                  state_q    <= START_BIT;
                  cnt_q      <= '0;
                  RX_Active  <= 1'b1;
                  cpb_q      <= w_cpb;
                  last_idx_q <= w_last_idx;
                  two_stop_q <= w_two_stop;
                  shift_q    <= '0;
                  err_q      <= 1'b0;
               end
            end
            START_BIT: begin
               if (cnt_q == w_half_m1) begin
                  cnt_q <= '0;
                  if (!w_rx_s) begin
                     state_q   <= DATA_BITS;
                     bit_idx_q <= '0;
                  end else begin
                     state_q   <= IDLE;
                     RX_Active <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + 14'd1;
               end
            end
            DATA_BITS: begin
               if (cnt_q == w_cpb_m1) begin
                  cnt_q            <= '0;
                  shift_q[bit_idx_q] <= w_rx_s;
                  if (bit_idx_q == last_idx_q) begin
                     state_q    <= STOP_BITS;
                     stop_idx_q <= 1'b0;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end else begin
                  cnt_q <= cnt_q + 14'd1;
               end
            end
            STOP_BITS: begin
               if (cnt_q == w_cpb_m1) begin
                  cnt_q <= '0;
                  if (two_stop_q && !stop_idx_q) begin
                     stop_idx_q <= 1'b1;
                     err_q      <= err_q | ~w_rx_s;
                  end else begin
                     // Outputs registered here so they are visible during CLEAN_UP.
                     state_q      <= CLEAN_UP;
                     RX_DV        <= 1'b1;
                     RX_BYTE      <= shift_q & w_mask;
                     RX_Frame_Err <= err_q | ~w_rx_s;
                     RX_Active    <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + 14'd1;
               end
            end
            CLEAN_UP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q   <= IDLE;
               RX_Active <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_recv.sv
`default_nettype none
// ============================================================================
// tb_uart_recv : directed self-checking bench for uart_recv
// Revision     : 1.0
// ============================================================================
module tb_uart_recv;

   localparam int BIT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        RX_serial;
   logic [25:0] clk_freq;
   logic [19:0] uart_baud;
   logic [3:0]  data_bits_rx;
   logic [1:0]  stop_bits_rx;
   logic        RX_DV;
   logic [7:0]  RX_BYTE;
   logic        RX_Active;
   logic        RX_Frame_Err;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          dv_count = 0;
   int          dv_cyc   = 0;
   int          err_count = 0;
   int          act_cnt  = 0;
   int          start_cyc = 0;
   int          base;
   int          base_err;
   logic [7:0]  dv_byte  = 8'h00;
   logic        dv_err   = 1'b0;

   uart_recv #(.SYNC_STAGES(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .RX_serial    (RX_serial),
      .clk_freq     (clk_freq),
      .uart_baud    (uart_baud),
      .data_bits_rx (data_bits_rx),
      .stop_bits_rx (stop_bits_rx),
      .RX_DV        (RX_DV),
      .RX_BYTE      (RX_BYTE),
      .RX_Active    (RX_Active),
      .RX_Frame_Err (RX_Frame_Err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (RX_DV) begin
         dv_count = dv_count + 1;
         dv_cyc   = cyc;
         dv_byte  = RX_BYTE;
         dv_err   = RX_Frame_Err;
      end
      if (RX_Frame_Err) err_count = err_count + 1;
      if (RX_Active)    act_cnt   = act_cnt + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] data, input int nbits,
                             input int nstop, input logic stop_val);
      start_cyc = cyc;
      RX_serial = 1'b0;
      tick(BIT);
      for (int i = 0; i < nbits; i++) begin
         RX_serial = data[i];
         tick(BIT);
      end
      for (int s = 0; s < nstop; s++) begin
         RX_serial = stop_val;
         tick(BIT);
      end
      RX_serial = 1'b1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst          = 1'b1;
      RX_serial    = 1'b1;
      clk_freq     = 26'd160;
      uart_baud    = 20'd10;
      data_bits_rx = 4'd8;
      stop_bits_rx = 2'd1;
      tick(3);
      check("reset_dv",     {31'd0, RX_DV},        32'd0);
      check("reset_byte",   {24'd0, RX_BYTE},      32'd0);
      check("reset_active", {31'd0, RX_Active},    32'd0);
      check("reset_ferr",   {31'd0, RX_Frame_Err}, 32'd0);
      rst = 1'b0;
      tick(10);

      // 8N1 frame 0xA5
      base = dv_count; base_err = err_count; act_cnt = 0;
      send_frame(8'hA5, 8, 1, 1'b1);
      check("a5_dv_count", dv_count - base, 32'd1);
      check("a5_byte",     {24'd0, dv_byte}, 32'hA5);
      check("a5_ferr",     err_count - base_err, 32'd0);
      check("a5_latency",  dv_cyc - start_cyc, 32'd155);
      check("a5_active",   act_cnt, 32'd152);
      tick(20);

      // 5 data bits, 2 stop bits
      data_bits_rx = 4'd5; stop_bits_rx = 2'd2;
      base = dv_count;
      send_frame(8'h16, 5, 2, 1'b1);
      check("d5s2_dv_count", dv_count - base, 32'd1);
      check("d5s2_byte",     {24'd0, dv_byte}, 32'h16);
      check("d5s2_latency",  dv_cyc - start_cyc, 32'd123);
      check("d5s2_ferr",     {31'd0, dv_err}, 32'd0);
      tick(20);

      // short glitch on the idle line
      data_bits_rx = 4'd8; stop_bits_rx = 2'd1;
      base = dv_count; act_cnt = 0;
      RX_serial = 1'b0;
      tick(5);
      RX_serial = 1'b1;
      tick(30);
      check("glitch_dv_count", dv_count - base, 32'd0);
      check("glitch_active",   {31'd0, RX_Active}, 32'd0);
      check("glitch_byte",     {24'd0, RX_BYTE}, 32'h16);
      check("glitch_act_len",  act_cnt, 32'd8);

      // stop bit low -> framing error, byte still delivered
      base = dv_count; base_err = err_count;
      send_frame(8'h3C, 8, 1, 1'b0);
      tick(40);
      check("ferr_dv_count",  dv_count - base, 32'd1);
      check("ferr_byte",      {24'd0, dv_byte}, 32'h3C);
      check("ferr_flag_w_dv", {31'd0, dv_err}, 32'd1);
      check("ferr_pulses",    err_count - base_err, 32'd1);

      // back-to-back 7-bit frames
      data_bits_rx = 4'd7;
      base = dv_count;
      send_frame(8'h00, 7, 1, 1'b1);
      check("b2b0_byte", {24'd0, dv_byte}, 32'h00);
      check("b2b0_cnt",  dv_count - base, 32'd1);
      send_frame(8'hFF, 7, 1, 1'b1);
      check("b2b1_byte", {24'd0, dv_byte}, 32'h7F);
      send_frame(8'h55, 7, 1, 1'b1);
      check("b2b2_byte", {24'd0, dv_byte}, 32'h55);
      check("b2b_dv_count", dv_count - base, 32'd3);
      check("b2b_ferr",  {31'd0, dv_err}, 32'd0);
      tick(20);

      // reset in the middle of data bit 3 of frame 0x81
      data_bits_rx = 4'd8;
      base = dv_count;
      RX_serial = 1'b0; tick(BIT);
      RX_serial = 1'b1; tick(BIT);
      RX_serial = 1'b0; tick(BIT);
      RX_serial = 1'b0; tick(BIT);
      RX_serial = 1'b0; tick(8);
      check("pre_rst_active", {31'd0, RX_Active}, 32'd1);
      rst = 1'b1;
      #2;
      check("async_rst_active", {31'd0, RX_Active}, 32'd0);
      check("async_rst_byte",   {24'd0, RX_BYTE},   32'h00);
      check("async_rst_dv",     {31'd0, RX_DV},     32'd0);
      tick(3);
      rst = 1'b0;
      RX_serial = 1'b1;
      tick(20);
      send_frame(8'h42, 8, 1, 1'b1);
      tick(20);
      check("post_rst_dv_count", dv_count - base, 32'd1);
      check("post_rst_byte",     {24'd0, dv_byte}, 32'h42);
      check("post_rst_outbyte",  {24'd0, RX_BYTE}, 32'h42);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_recv.md
Name: uart_recv

Overview:
- UART receiver; the receiving end of the serial link driven by the team's UART transmitter.
- Deserialises one asynchronous frame per transfer: 1 start bit, 5–8 data bits sent LSB first, 1 or 2 stop bits, no parity.
- Baud rate, data width and stop-bit count are runtime inputs, in the same form the transmitter uses.
- Outputs the received byte with a one-cycle valid pulse, plus a framing-error flag. The UART verification environment uses it as the loopback sink.

Parameters:
- SYNC_STAGES, 2, number of flops in the RX_serial metastability synchroniser (minimum 2).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- RX_serial  input  1  serial line; idles high
- clk_freq  input  26  clock frequency in Hz
- uart_baud  input  20  baud rate in bit/s
- data_bits_rx  input  4  data bits per frame: 5, 6, 7 or 8
- stop_bits_rx  input  2  stop bits per frame: 1 or 2
- RX_DV  output  1  one-cycle pulse: RX_BYTE is valid
- RX_BYTE  output  8  received data, right-aligned; unused upper bits are 0
- RX_Active  output  1  high while a frame is being received
- RX_Frame_Err  output  1  one-cycle pulse, coincident with RX_DV, when any stop bit sampled low

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, counters=0, RX_DV=0, RX_BYTE=8'h00, RX_Active=0, RX_Frame_Err=0. Synchroniser flops reset to 1.
- CLKS_PER_BITS = clk_freq / uart_baud, truncating integer division, 14-bit result. Operation is legal only for CLKS_PER_BITS ≥ 4.
- HALF = CLKS_PER_BITS >> 1.
- All decisions use the synchronised line rx_s, which lags RX_serial by SYNC_STAGES cycles.
- IDLE:
  - rx_s==0 → START_BIT; counter=0; RX_Active=1.
  - On entry to START_BIT, latch data_bits_rx, stop_bits_rx and CLKS_PER_BITS. Input changes mid-frame are ignored.
  - A latched data_bits outside 5–8 is treated as 8. A latched stop_bits of 0 or 3 is treated as 1.
- START_BIT:
  - Count to HALF-1, then re-sample rx_s.
  - rx_s==0 → DATA_BITS; counter=0; bit_index=0.
  - rx_s==1 → glitch: return to IDLE, RX_Active=0, no RX_DV.
- DATA_BITS:
  - At counter==CLKS_PER_BITS-1 (mid-bit), store rx_s into shift register bit bit_index; counter=0.
  - bit_index==N-1 → STOP_BITS; otherwise bit_index+1.
  - Bits N..7 of the assembled byte are forced to 0.
- STOP_BITS:
  - Sample mid-bit at counter==CLKS_PER_BITS-1.
  - With 2 stop bits, a second sample is taken one further bit period later.
  - Any stop sample ==0 sets an internal error flag.
  - After the last stop sample → CLEAN_UP.
- CLEAN_UP (one cycle):
  - RX_BYTE updates to the assembled byte.
  - RX_DV=1 and RX_Frame_Err=error flag, for exactly this cycle.
  - RX_Active=0; next state IDLE.
  - RX_BYTE holds until the next CLEAN_UP. A byte is delivered even when a framing error occurs.
- Back-to-back frames: IDLE accepts a new start edge on the cycle after CLEAN_UP.
  - A start bit that begins during the final stop-bit half-period is not lost, because rx_s is re-checked in IDLE.
- Break condition (line held low): after a framing-error frame with data 0x00, the FSM waits in IDLE-entry/START_BIT re-triggers. No lockup; each re-trigger is a normal frame attempt.
- Unknown state encoding → IDLE.
- Reset asserted mid-frame: immediate return to reset values; no RX_DV for the partial frame.
- Latency: RX_DV rises 1 cycle after the final stop-bit sample, SYNC_STAGES+1 cycles after that sample's line instant.

Test Plan:
- clk_freq=160, uart_baud=10 (16 clk/bit), 8 data bits, 1 stop bit; drive frame 0xA5 → one RX_DV pulse, RX_BYTE=8'hA5, RX_Frame_Err=0, RX_Active high for ~10 bit periods.
- Same rate, 5 data bits, 2 stop bits; drive 5'b10110 → RX_BYTE=8'h16. RX_DV occurs one bit period later than the 1-stop-bit case.
- Line low pulse of 5 clocks (< HALF) from idle → RX_Active returns to 0, no RX_DV, RX_BYTE unchanged.
- 8-bit frame 0x3C with the stop bit driven low → RX_DV=1 and RX_Frame_Err=1 in the same cycle, RX_BYTE=8'h3C.
- Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap, 7 data bits → three RX_DV pulses with RX_BYTE 0x00, 0x7F, 0x55.
- Reset asserted at data bit 3 of frame 0x81 → outputs return to reset values asynchronously. The next clean frame 0x42 yields RX_BYTE=8'h42.
